// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM.
// Sequences fetch/decode/execute and drives datapath strobes.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RWB     = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDI_EX = 4'd10,
    ADDI_WB = 4'd11
  } state_e;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        op_d    = opcode;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RT:        state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EX;
          default: begin
            state_d    = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (op_q == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = FETCH;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = RWB;
      end
      RWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCSource    = 2'b01;
        PCWriteCond = 1'b1;
        instr_done  = 1'b1;
        state_d     = FETCH;
      end
      JUMP: begin
        PCSource   = 2'b10;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = ADDI_WB;
      end
      ADDI_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // reset kills every side-effecting strobe, whatever state we are in
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemWrite    = 1'b0;
      MemRead     = 1'b0;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized + directed bench for multicycle_control.
// Reference model walks a per-instruction path of states.
module tb_multicycle_control;

  logic       clk, reset, mem_ready;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] BAD  = 6'b111111;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw;
    logic       m2r, rdst, rwr, asa;
    logic [1:0] asb, aop, pcs;
    logic       done, ill;
  } ctl_t;

  int errs = 0;
  int checks = 0;
  int cur = 0;
  int path[$];
  int done_cnt, mw_cnt, ill_cnt, rw_cnt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op inside {LW, SW, RT, BEQ, JMP, ADDI};
  endfunction

  function automatic ctl_t ref_ctl(input int s, input logic mr,
                                   input logic rst, input logic [5:0] op);
    ctl_t e;
    e = '0;
    case (s)
      0:  begin e.mrd = 1; e.asb = 2'd1; e.irw = mr; e.pcw = mr; end
      1:  begin e.asb = 2'd3; e.ill = !legal(op); end
      2, 10: begin e.asa = 1; e.asb = 2'd2; end
      3:  begin e.mrd = 1; e.iord = 1; end
      4:  begin e.m2r = 1; e.rwr = 1; e.done = 1; end
      5:  begin e.mwr = 1; e.iord = 1; e.done = mr; end
      6:  begin e.asa = 1; e.aop = 2'd2; end
      7:  begin e.rdst = 1; e.rwr = 1; e.done = 1; end
      8:  begin
        e.asa = 1; e.aop = 2'd1; e.pcs = 2'd1;
        e.pcwc = 1; e.done = 1;
      end
      9:  begin e.pcs = 2'd2; e.pcw = 1; e.done = 1; end
      11: begin e.rwr = 1; e.done = 1; end
      default: e = '0;
    endcase
    if (rst) begin
      e.pcw = 0; e.pcwc = 0; e.irw = 0; e.rwr = 0;
      e.mwr = 0; e.mrd = 0; e.done = 0; e.ill = 0;
    end
    return e;
  endfunction

  // Instruction-level model: DECODE lays out the remaining path,
  // FETCH/MEMRD/MEMWR wait on mem_ready.
  task automatic model_adv(input logic [5:0] op, input logic mr,
                           input logic rst);
    if (rst) begin
      cur = 0;
      path.delete();
    end else if ((cur == 0 || cur == 3 || cur == 5) && !mr) begin
      cur = cur;
    end else if (cur == 0) begin
      cur = 1;
    end else begin
      if (cur == 1) begin
        path.delete();
        case (op)
          LW:   path = '{2, 3, 4};
          SW:   path = '{2, 5};
          RT:   path = '{6, 7};
          BEQ:  path = '{8};
          JMP:  path = '{9};
          ADDI: path = '{10, 11};
          default: path.delete();
        endcase
      end
      cur = (path.size() > 0) ? path.pop_front() : 0;
    end
  endtask

  task automatic step(input logic [5:0] op, input logic mr,
                      input logic rst);
    ctl_t g, e;
    opcode = op;
    mem_ready = mr;
    reset = rst;
    #4;
    g = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
         MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
         PCSource, instr_done, illegal_op};
    e = ref_ctl(cur, mr, rst, op);
    chk("state", 32'(state), 32'(cur));
    chk("ctl", 32'(g), 32'(e));
    if (instr_done) done_cnt++;
    if (MemWrite) mw_cnt++;
    if (illegal_op) ill_cnt++;
    if (RegWrite) rw_cnt++;
    @(posedge clk);
    #1;
    model_adv(op, mr, rst);
  endtask

  task automatic clr();
    done_cnt = 0; mw_cnt = 0; ill_cnt = 0; rw_cnt = 0;
  endtask

  logic [5:0] ops [7];
  logic [5:0] rop;

  initial begin
    ops = '{LW, SW, RT, BEQ, JMP, ADDI, BAD};
    opcode = '0;
    mem_ready = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    cur = 0;
    step(RT, 1, 1);
    step(RT, 1, 0);
    chk("post_reset_state", 32'(state), 32'd1);

    // lw, no stalls
    repeat (3) step(RT, 1, 1);
    clr();
    repeat (5) step(LW, 1, 0);
    chk("lw_done", 32'(done_cnt), 32'd1);
    chk("lw_rw", 32'(rw_cnt), 32'd1);
    chk("lw_back", 32'(state), 32'd0);

    // sw with three stalled MEMWR cycles
    clr();
    repeat (3) step(SW, 1, 0);
    repeat (3) step(SW, 0, 0);
    step(SW, 1, 0);
    chk("sw_mw", 32'(mw_cnt), 32'd4);
    chk("sw_done", 32'(done_cnt), 32'd1);
    chk("sw_back", 32'(state), 32'd0);

    // R-type then beq
    clr();
    repeat (4) step(RT, 1, 0);
    repeat (3) step(BEQ, 1, 0);
    chk("rb_done", 32'(done_cnt), 32'd2);

    // illegal opcode
    clr();
    repeat (2) step(BAD, 1, 0);
    chk("ill_cnt", 32'(ill_cnt), 32'd1);
    chk("ill_done", 32'(done_cnt), 32'd0);
    chk("ill_back", 32'(state), 32'd0);

    // opcode flips during MEMADR: op_q must steer
    step(LW, 1, 0);
    step(LW, 1, 0);
    step(RT, 1, 0);
    chk("opq_memrd", 32'(state), 32'd3);
    step(RT, 1, 0);
    step(RT, 1, 0);

    // reset during MEMRD, then a clean jump
    clr();
    repeat (3) step(LW, 1, 0);
    chk("rst_at_memrd", 32'(state), 32'd3);
    step(LW, 1, 1);
    chk("rst_ret", 32'(state), 32'd0);
    repeat (3) step(JMP, 1, 0);
    chk("rst_j_done", 32'(done_cnt), 32'd1);

    // reset during a MEMWR stall
    repeat (3) step(SW, 1, 0);
    step(SW, 0, 0);
    step(SW, 0, 1);
    chk("rst_memwr", 32'(state), 32'd0);

    for (int i = 0; i < 4000; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 6'($urandom)
                                        : ops[$urandom_range(0, 6)];
      step(rop, $urandom_range(0, 3) != 0,
           $urandom_range(0, 59) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
